// File: rtl/fb_rect_fill.sv
// fb_rect_fill: Avalon-MM burst-write master filling a frame-buffer rectangle with a constant word
module fb_rect_fill (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [2:0]  avalon_slave_address_i,
  input  logic        avalon_slave_read_i,
  output logic [31:0] avalon_slave_readdata_o,
  input  logic        avalon_slave_write_i,
  input  logic [31:0] avalon_slave_writedata_i,
  output logic [31:0] avalon_master_address_o,
  output logic [4:0]  avalon_master_burstcount_o,
  output logic        avalon_master_write_o,
  output logic [31:0] avalon_master_writedata_o,
  input  logic        avalon_master_waitrequest_i
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, BURST = 2'd2, FIN = 2'd3;
  logic [31:0] base_q, color_q, rd_q, lbase_q, lcolor_q, addr_q, wd_q, rd_d, addr_d;
  logic [8:0]  x0_q, y0_q, w_q, h_q, lx0_q;
  logic [9:0]  xend_q, yend_q, x_q, y_q, rem_d, nx_d;
  logic [3:0]  beats_q, len_d;
  logic [4:0]  bc_q;
  logic [1:0]  st_q;
  logic        frame_q, lframe_q, busy_q, done_q, err_q, wr_q, wr_en, start, ok;
  assign wr_en = avalon_slave_write_i && !avalon_slave_read_i;
  assign start = wr_en && avalon_slave_address_i == 3'd5 && avalon_slave_writedata_i[0] && !busy_q;
  assign ok = w_q != 9'd0 && h_q != 9'd0 && ({1'b0, x0_q} + {1'b0, w_q}) <= 10'd320
              && ({1'b0, y0_q} + {1'b0, h_q}) <= 10'd480;
  assign rem_d = xend_q - x_q;
  assign len_d = rem_d > 10'd8 ? 4'd8 : rem_d[3:0];
  assign nx_d = x_q + {5'd0, bc_q};
  assign addr_d = lbase_q + (lframe_q ? 32'h0009_6000 : 32'h0) + ({22'd0, y_q} << 10)
                  + ({22'd0, y_q} << 8) + ({22'd0, x_q} << 2);
  assign rd_d = avalon_slave_address_i == 3'd0 ? base_q :
                avalon_slave_address_i == 3'd1 ? {31'd0, frame_q} :
                avalon_slave_address_i == 3'd2 ? {7'd0, y0_q, 7'd0, x0_q} :
                avalon_slave_address_i == 3'd3 ? {7'd0, h_q, 7'd0, w_q} :
                avalon_slave_address_i == 3'd4 ? color_q :
                avalon_slave_address_i == 3'd5 ? {29'd0, done_q, err_q, busy_q} : 32'd0;
  assign avalon_slave_readdata_o = rd_q;
  assign avalon_master_address_o = addr_q;
  assign avalon_master_burstcount_o = bc_q;
  assign avalon_master_write_o = wr_q;
  assign avalon_master_writedata_o = wd_q;
  // Software-visible register file; a read in the same cycle as a write drops the write.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      {base_q, color_q, rd_q, frame_q, x0_q, y0_q, w_q, h_q} <= '0;
    end else begin
      if (avalon_slave_read_i) rd_q <= rd_d;
      if (wr_en && avalon_slave_address_i == 3'd0) base_q <= avalon_slave_writedata_i;
      if (wr_en && avalon_slave_address_i == 3'd1) frame_q <= avalon_slave_writedata_i[0];
      if (wr_en && avalon_slave_address_i == 3'd2) {y0_q, x0_q} <= {avalon_slave_writedata_i[24:16], avalon_slave_writedata_i[8:0]};
      if (wr_en && avalon_slave_address_i == 3'd3) {h_q, w_q} <= {avalon_slave_writedata_i[24:16], avalon_slave_writedata_i[8:0]};
      if (wr_en && avalon_slave_address_i == 3'd4) color_q <= avalon_slave_writedata_i;
    end
  end
  // Fill engine: latches a job on start, then walks rows issuing bursts that never cross a row end.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      {lbase_q, lcolor_q, addr_q, wd_q, lx0_q, xend_q, yend_q, x_q, y_q} <= '0;
      {beats_q, bc_q, st_q, lframe_q, busy_q, done_q, err_q, wr_q} <= '0;
    end else begin
      case (st_q)
        IDLE: if (start) begin
          lbase_q <= base_q;
          lframe_q <= frame_q;
          lcolor_q <= color_q;
          lx0_q <= x0_q;
          x_q <= {1'b0, x0_q};
          y_q <= {1'b0, y0_q};
          xend_q <= {1'b0, x0_q} + {1'b0, w_q};
          yend_q <= {1'b0, y0_q} + {1'b0, h_q};
          done_q <= 1'b0;
          err_q <= !ok;
          busy_q <= ok;
          st_q <= ok ? SETUP : IDLE;
        end
        SETUP: begin
          addr_q <= addr_d;
          bc_q <= {1'b0, len_d};
          beats_q <= len_d;
          wd_q <= lcolor_q;
          wr_q <= 1'b1;
          st_q <= BURST;
        end
        BURST: if (wr_q && !avalon_master_waitrequest_i) begin
          beats_q <= beats_q - 4'd1;
          if (beats_q == 4'd1) begin
            wr_q <= 1'b0;
            if (nx_d < xend_q) begin
              x_q <= nx_d;
              st_q <= SETUP;
            end else if (y_q + 10'd1 < yend_q) begin
              x_q <= {1'b0, lx0_q};
              y_q <= y_q + 10'd1;
              st_q <= SETUP;
            end else st_q <= FIN;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          st_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: scoreboard bench for the rectangle fill master
module tb_fb_rect_fill;
  typedef struct {logic [31:0] a; logic [4:0] b; logic [31:0] d;} beat_t;
  logic clk = 0, rst_n = 0;
  logic [2:0] s_addr = 0;
  logic s_read = 0, s_write = 0, m_write, m_wait = 0;
  logic [31:0] s_rdata, s_wdata = 0, m_addr, m_wdata, st;
  logic [4:0] m_bc;
  int total = 0, bad = 0, acc = 0;
  beat_t sb[$];

  fb_rect_fill dut (
    .clk_i(clk), .reset_ni(rst_n),
    .avalon_slave_address_i(s_addr), .avalon_slave_read_i(s_read),
    .avalon_slave_readdata_o(s_rdata), .avalon_slave_write_i(s_write),
    .avalon_slave_writedata_i(s_wdata),
    .avalon_master_address_o(m_addr), .avalon_master_burstcount_o(m_bc),
    .avalon_master_write_o(m_write), .avalon_master_writedata_o(m_wdata),
    .avalon_master_waitrequest_i(m_wait));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Every presented beat must match the queue head; stalled beats are not popped.
  always @(negedge clk) if (m_write) begin
    if (sb.size() == 0) chk("extra_write", 1, 0);
    else begin
      chk("addr", m_addr, sb[0].a);
      chk("bc", m_bc, sb[0].b);
      chk("data", m_wdata, sb[0].d);
      if (!m_wait) begin
        void'(sb.pop_front());
        acc++;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    s_addr = a; s_wdata = d; s_write = 1;
    @(posedge clk); #1;
    s_write = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    s_addr = a; s_read = 1;
    @(posedge clk); #1;
    s_read = 0;
    d = s_rdata;
  endtask

  task automatic push(input logic [31:0] base, input bit fr, input int x0, y0, w, h, input logic [31:0] col);
    int x, len;
    beat_t b;
    for (int y = y0; y < y0 + h; y++) begin
      x = x0;
      while (x < x0 + w) begin
        len = (x0 + w - x > 8) ? 8 : x0 + w - x;
        b.a = base + (fr ? 32'h96000 : 32'h0) + 32'(y * 1280 + x * 4);
        b.b = 5'(len);
        b.d = col;
        for (int k = 0; k < len; k++) sb.push_back(b);
        x += len;
      end
    end
  endtask

  task automatic fill(input logic [31:0] base, input bit fr, input int x0, y0, w, h, input logic [31:0] col);
    wr(0, base);
    wr(1, {31'd0, fr});
    wr(2, {7'd0, 9'(y0), 7'd0, 9'(x0)});
    wr(3, {7'd0, 9'(h), 7'd0, 9'(w)});
    wr(4, col);
    if (w != 0 && h != 0 && x0 + w <= 320 && y0 + h <= 480) push(base, fr, x0, y0, w, h, col);
    acc = 0;
    wr(5, 1);
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    for (int i = 0; i < 3000; i++) begin
      rd(5, d);
      if (!d[0]) return;
    end
    chk("timeout", 1, 0);
  endtask

  initial begin
    #2 chk("rst_write", m_write, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_bc", m_bc, 0);
    chk("rst_rdata", s_rdata, 0);
    #21 rst_n = 1;
    rd(5, st); chk("rst_status", st, 0);
    rd(6, st); chk("rd6", st, 0);

    fill(32'h1000, 0, 0, 0, 10, 1, 32'hABCD1234);
    wait_idle();
    rd(5, st); chk("t1_status", st, 4);
    chk("t1_beats", acc, 10);
    chk("t1_sb", sb.size(), 0);

    fill(32'h0, 1, 316, 2, 4, 2, 32'h0F0F_F0F0);
    wait_idle();
    rd(5, st); chk("t2_status", st, 4);
    chk("t2_beats", acc, 8);

    fill(32'h4000, 0, 8, 5, 8, 1, 32'h1234_5678);
    for (int i = 0; i < 20 && !m_write; i++) begin @(posedge clk); #1; end
    m_wait = 1;
    repeat (3) @(posedge clk);
    #1 m_wait = 0;
    for (int i = 0; i < 50 && acc < 4; i++) begin @(posedge clk); #1; end
    m_wait = 1;
    repeat (3) @(posedge clk);
    #1 m_wait = 0;
    wait_idle();
    chk("t3_beats", acc, 8);
    chk("t3_sb", sb.size(), 0);

    fill(32'h0, 0, 0, 0, 0, 1, 32'h1);
    rd(5, st); chk("e_w0", st, 2);
    fill(32'h0, 0, 300, 0, 21, 1, 32'h1);
    rd(5, st); chk("e_x", st, 2);
    fill(32'h0, 0, 0, 479, 4, 2, 32'h1);
    rd(5, st); chk("e_y", st, 2);
    chk("e_beats", acc, 0);

    fill(32'h8000, 0, 10, 20, 40, 2, 32'h5555_AAAA);
    rd(5, st); chk("t5_busy", st, 1);
    wr(4, 0);
    wr(5, 1);
    wait_idle();
    rd(5, st); chk("t5_status", st, 4);
    rd(4, st); chk("t5_color", st, 0);
    chk("t5_beats", acc, 80);

    fill(32'h0, 0, 0, 0, 16, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 50 && acc < 2; i++) begin @(posedge clk); #1; end
    #1 rst_n = 0;
    #1 chk("rst_async_wr", m_write, 0);
    sb.delete();
    @(posedge clk); #3 rst_n = 1;
    chk("rst2_addr", m_addr, 0);
    chk("rst2_data", m_wdata, 0);
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), st);
      chk($sformatf("rst2_reg%0d", a), st, 0);
    end
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_rect_fill.md
# fb_rect_fill

Avalon-MM burst-write master that fills a rectangle of the active frame buffer with a constant 32-bit word (two packed 16-bit 4:4:4 pixels). It is the producer side of the frame-buffer path: it writes the same memory layout that the VGA scan-out engine burst-reads. The layout is 320 words per line, 1280 bytes per line, and frame 1 sits at +0x00096000. Software programs it through a small Avalon slave register file, so the CPU can clear or fill regions without per-pixel writes.

## Interface
No parameters; geometry fixed: 320 words/line, 480 lines, frame size 0x00096000, max burst 8.
- clk  in  1  system clock
- reset  in  1  reset; one clock; reset is asynchronous and active-low
- avalon_slave_address  in  3  register select
- avalon_slave_read  in  1  register read strobe
- avalon_slave_readdata  out  32  registered read data
- avalon_slave_write  in  1  register write strobe
- avalon_slave_writedata  in  32  register write data
- avalon_master_address  out  32  byte address of burst
- avalon_master_burstcount  out  5  burst length, 1..8
- avalon_master_write  out  1  write request
- avalon_master_writedata  out  32  fill word
- avalon_master_waitrequest  in  1  beat stall

## Operation
- Registers (slave):
  - 0 BASE: frame buffer byte address.
  - 1 FRAME: bit0 selects frame 1.
  - 2 XY: [8:0] x0 word column, [24:16] y0 line.
  - 3 WH: [8:0] w words, [24:16] h lines.
  - 4 COLOR: fill word.
  - 5 CTRL/STATUS:
    - Write: bit0=1 requests start.
    - Read: {29'b0, done, error, busy}.
  - Reads of addresses 6-7 return 0.
- Start handling (bit0 written while idle):
  - Latch BASE, FRAME, x0, y0, w, h, COLOR; clear done and error.
  - Invalid if w==0, h==0, x0+w>320 or y0+h>480 (9-bit fields zero-extended). An invalid request sets error=1, leaves busy=0 and issues no transfers.
- Start while busy: ignored; no state change.
- Register writes while busy update the register file only. The active fill uses the latched copies.
- FSM:
  - IDLE: a valid start goes to SETUP with busy=1.
  - SETUP: compute address = BASE + (FRAME ? 0x96000 : 0) + y*1280 + x*4 and len = min(8, row_remaining). Drive address, burstcount=len, write=1 and writedata=COLOR. Go to BURST.
  - BURST: a beat is accepted when write && !waitrequest; decrement the beat counter on each accepted beat.
    - Last beat accepted with words left in the row: x += len, write=0, go to SETUP.
    - Row complete with lines left: x = x0, y += 1, go to SETUP.
    - Final row complete: go to IDLE with busy=0 and done=1.
- Bursts never cross a row end; every row restarts at x0.
- Arithmetic: y*1280 computed as (y<<10)+(y<<8), 32-bit, wrap modulo 2^32.

## Timing
- Reset (asynchronous assert, synchronous release): all registers 0, FSM IDLE.
  - Outputs: avalon_slave_readdata=0, address=0, burstcount=0, write=0, writedata=0.
  - Status: busy=0, error=0, done=0.
- Reset asserted mid-burst: write drops immediately (asynchronously) and the burst is abandoned. Software restarts the fill.
- Slave read latency 1 cycle. Readdata holds its value between reads. If read and write assert together, the read wins and the write is dropped.
- Start accepted at edge N: busy=1 after N; SETUP in cycle N+1; write=1 from edge N+1 onward.
- While waitrequest=1: address, burstcount, writedata and write hold stable.
- Burst rate: one beat per cycle with no stalls, plus one SETUP cycle (write=0) between bursts.
- Completion: the final beat is accepted at edge M; busy=0 and done=1 are visible after edge M+1.
- Throughput bound for a full 320×480 fill with no stalls: 480 × 40 × 9 cycles.

## Test plan
- BASE=0x1000, FRAME=0, XY=0, WH={h=1,w=10}, COLOR=0xABCD1234, no stalls.
  - Two bursts: addr 0x1000/bc 8, then addr 0x1020/bc 2; 10 beats of 0xABCD1234.
  - done=1, busy=0.
- FRAME=1, x0=316, y0=2, w=4, h=2, BASE=0.
  - Bursts: 0x96000+2560+1264 with bc 4, then 0x96000+3840+1264 with bc 4.
- waitrequest high for 3 cycles on the 1st and 5th beats of an 8-beat burst.
  - Address, burstcount and data stay stable; exactly 8 beats are accepted; no beat is lost or duplicated.
- Start with w=0, then with x0=300/w=21, then with y0=479/h=2.
  - Each sets error=1 with busy=0, and no master write occurs.
- Start while busy, plus a write to COLOR=0 mid-fill.
  - Second start ignored; the fill completes with the original COLOR; register 4 reads 0.
- Assert reset during beat 3 of a burst.
  - write=0 immediately; after release all status is 0 and registers are 0.
